param_seq_detector: RTL
=======================

Name: param_seq_detector

Overview:
- Parametrised Mealy serial-sequence detector; next generation of the fixed 4-bit "1011" detector.
- Pattern length, pattern value and match-counter width are parameters.
- Overlapping/non-overlapping mode is selected at run time; a valid qualifier lets the bit stream stall.
- Sits on a serial bit stream; drives a single-cycle Mealy match flag and a saturating match count for status logic.

Parameters:
- PAT_LEN, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011, target sequence; PATTERN[PAT_LEN-1] is the first bit received, PATTERN[0] the last.
- CNT_W, 8, width of match_cnt.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserts immediately, releases synchronously to clk).
- clr  input  1  synchronous clear of state, history and match_cnt; takes priority over in_valid.
- in_valid  input  1  qualifies in; when low, nothing advances.
- in  input  1  serial data bit.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled only on a matching cycle.
- out  output  1  Mealy match flag, combinational from state, in_valid and in.
- match_cnt  output  CNT_W  saturating count of matches since reset/clr.
- state_o  output  $clog2(PAT_LEN)  current matched-prefix length, for debug/verification.

Behaviour:
- State k = number of pattern prefix bits currently matched, 0..PAT_LEN-1. Encoded as a binary register, not one-hot.
- History register hist holds the last PAT_LEN-1 accepted bits; shifts only when in_valid=1.
- Reset (rst=0), asynchronous: k=0, hist=0, match_cnt=0. out=0 follows from in_valid/state gating.
- clr=1 at a clock edge has the same effect as reset, synchronously. out is forced to 0 during the clr cycle.
- in_valid=0: k, hist and match_cnt hold; out=0.
- out = in_valid & ~clr & (k==PAT_LEN-1) & (in==PATTERN[0]). Zero-cycle latency; high for exactly one cycle per match.
- Next-state on an accepted bit b:
  - Full match (out=1), overlap=1: k <= B, where B is the length of the longest proper border of PATTERN (longest proper suffix that is also a prefix). B is computed at elaboration.
  - Full match, overlap=0: k <= 0.
  - Otherwise: k <= the largest j, with j <= k+1 and j <= PAT_LEN-1, such that the last j bits of {hist,b} equal the first j pattern bits; 0 if none. This is the KMP fallback.
  - The j <= k+1 bound stops bits consumed by a prior non-overlapping match from being reused.
- match_cnt increments on each out=1 cycle and saturates at 2^CNT_W-1 (no wrap).
- overlap may change on any cycle. It affects only the next-state choice on a matching cycle and never changes out.
- Reset asserted mid-pattern discards the partial match. The first bit after release is treated as pattern bit 1.
- Patterns with no border (e.g. 1000) behave identically in both modes.

Optional Feature:
- Macro: SEQ_DET_CNT_EN.
- Defined: match_cnt counter implemented as above.
- Undefined: counter logic removed; match_cnt tied to 0. out and state behaviour unchanged.

Test Plan:
- Defaults, overlap=1, in_valid=1, stream 1,0,1,1,0,1,1,1,0,1,1 → out pulses on bits 4, 7 and 11; match_cnt=3 (SEQ_DET_CNT_EN defined).
- Same stream, overlap=0 → out pulses on bits 4 and 11 only; match_cnt=2.
- PATTERN=4'b1010, stream 1,0,1,0,1,0,1 → overlap=1: pulses on bits 4 and 6; overlap=0: pulse on bit 4 only, final state_o=3.
- in_valid toggled low for 3 cycles between bits 2 and 3 of 1011 → state_o holds at 2 while stalled, out=0 during the stall; pulse on bit 4; out never asserts while in_valid=0.
- CNT_W=2, eight back-to-back 1011 patterns → match_cnt saturates at 3. A clr pulse then gives match_cnt=0 and state_o=0 on the next cycle.
- rst driven low asynchronously mid-cycle after bits 1,0,1 → state_o=0 immediately. After release, stream 1,0,1,1 is needed for a pulse; a lone 1 does not complete the match.

Source files
------------

// File: rtl/param_seq_detector.sv
// Parametrised Mealy serial-sequence detector with run-time overlap select and a stall qualifier.
// Optional saturating match counter is built only when SEQ_DET_CNT_EN is defined.
//
// state | meaning
// ------+-----------------------------------------------------------
// 0     | no pattern prefix matched
// k     | first k pattern bits matched (1 <= k <= PAT_LEN-2)
// P-1   | all but the last bit matched; next accepted bit may hit

module param_seq_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic                       in,
    input  logic                       overlap,
    output logic                       out,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [$clog2(PAT_LEN)-1:0] state_o
);

    localparam int SW = $clog2(PAT_LEN);
    localparam logic [SW-1:0] LAST = SW'(PAT_LEN - 1);

    // Longest proper suffix of PATTERN that is also a prefix.
    function automatic int border_len();
        int   best;
        logic eq;
        best = 0;
        for (int b = 1; b < PAT_LEN; b++) begin
            eq = 1'b1;
            for (int i = 0; i < b; i++)
                if (PATTERN[i] != PATTERN[PAT_LEN-b+i]) eq = 1'b0;
            if (eq) best = b;
        end
        return best;
    endfunction

    localparam int BORDER = border_len();

    // Longest prefix (<= cur+1) that ends the window; the bound keeps bits
    // already consumed by a non-overlapping match from being reused.
    function automatic logic [SW-1:0] kmp_next(input logic [PAT_LEN-1:0] w,
                                               input logic [SW-1:0]      cur);
        logic [SW-1:0] best;
        logic          eq;
        best = '0;
        for (int j = 1; j < PAT_LEN; j++) begin
            eq = 1'b1;
            for (int i = 0; i < j; i++)
                if (w[i] != PATTERN[PAT_LEN-j+i]) eq = 1'b0;
            if (eq && (j <= int'(cur) + 1)) best = SW'(j);
        end
        return best;
    endfunction

    logic [SW-1:0]      k;
    logic [SW-1:0]      k_nxt;
    logic [PAT_LEN-2:0] hist;
    logic [PAT_LEN-1:0] win;

    assign win     = {hist, in};
    assign state_o = k;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k    <= '0;
            hist <= '0;
        end else if (clr) begin
            k    <= '0;
            hist <= '0;
        end else if (in_valid) begin
            k    <= k_nxt;
            hist <= win[PAT_LEN-2:0];
        end
    end

    always_comb begin
        k_nxt = k;
        if (out) begin
            k_nxt = overlap ? SW'(BORDER) : '0;
        end else begin
            k_nxt = kmp_next(win, k);
        end
    end

    always_comb begin
        out = in_valid & ~clr & (k == LAST) & (in == PATTERN[0]);
    end

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (out && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match_cnt = cnt;
`else
    assign match_cnt = '0;
`endif

endmodule
